// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order retirement of up to two entries per cycle,
// several writeback ports, same-cycle operand bypass and a self-raised redirect flush.
module reorder_buffer_mc #(
    parameter int unsigned DEPTH_W  = 4,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned OP_W     = 6,
    parameter int unsigned REG_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         alloc_valid,
    input  logic [1:0]                   alloc_kind,
    input  logic [OP_W-1:0]              alloc_op,
    input  logic [REG_W-1:0]             alloc_rd,
    input  logic                         alloc_ready,
    input  logic [XLEN-1:0]              alloc_val,
    input  logic [XLEN-1:0]              alloc_addr,
    input  logic                         alloc_pred,
    input  logic [XLEN-1:0]              alloc_pc,
    input  logic                         alloc_c,
    output logic [DEPTH_W-1:0]           alloc_id,
    output logic                         rob_full,
    output logic [DEPTH_W:0]             rob_count,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*DEPTH_W-1:0]  wb_id,
    input  logic [WB_PORTS*XLEN-1:0]     wb_val,
    input  logic [WB_PORTS*XLEN-1:0]     wb_addr,
    input  logic [2*DEPTH_W-1:0]         q_id,
    output logic [1:0]                   q_ready,
    output logic [2*XLEN-1:0]            q_val,
    input  logic                         mem_busy,
    output logic [1:0]                   commit_valid,
    output logic [2*REG_W-1:0]           commit_rd,
    output logic [2*XLEN-1:0]            commit_val,
    output logic                         mem_en,
    output logic [OP_W-1:0]              mem_op,
    output logic [XLEN-1:0]              mem_addr,
    output logic [XLEN-1:0]              mem_val,
    output logic                         bp_en,
    output logic [XLEN-1:0]              bp_pc,
    output logic                         bp_taken,
    output logic                         bp_correct,
    output logic                         rob_flush,
    output logic [XLEN-1:0]              rob_correct_pc
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;
    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;
    localparam logic [1:0] KIND_JALR   = 2'd3;
    localparam logic [DEPTH_W:0] COUNT_FULL = DEPTH;
    localparam logic [DEPTH_W:0] COUNT_TWO  = 2;

    logic [DEPTH_W-1:0] head_q, tail_q;
    logic [DEPTH_W:0]   count_q, count_d;

    logic [1:0]       kind_q  [DEPTH];
    logic [OP_W-1:0]  op_q    [DEPTH];
    logic [REG_W-1:0] rd_q    [DEPTH];
    logic [XLEN-1:0]  val_q   [DEPTH];
    logic [XLEN-1:0]  addr_q  [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] c_q;

    logic [DEPTH_W-1:0] wb_idx [WB_PORTS];
    logic [DEPTH_W-1:0] wb_off [WB_PORTS];
    logic [XLEN-1:0]    wb_val_a  [WB_PORTS];
    logic [XLEN-1:0]    wb_addr_a [WB_PORTS];
    logic [WB_PORTS-1:0] wb_hit;

    logic [DEPTH_W-1:0] head1;
    logic [1:0]         kind0;
    logic               alloc_acc, fire0, fire1, mispredict;
    logic [1:0]         n_commit;
    logic [XLEN-1:0]    branch_fall;

    assign alloc_id  = tail_q;
    assign rob_count = count_q;
    assign rob_full  = (count_q == COUNT_FULL);
    assign alloc_acc = alloc_valid && !rob_full && !rob_flush;

    // Writebacks only land on live entries; offsets are taken relative to head.
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_idx[p]    = wb_id[p*DEPTH_W +: DEPTH_W];
            wb_val_a[p]  = wb_val[p*XLEN +: XLEN];
            wb_addr_a[p] = wb_addr[p*XLEN +: XLEN];
            wb_off[p]    = wb_idx[p] - head_q;
            wb_hit[p]    = wb_valid[p] && ({1'b0, wb_off[p]} < count_q) && !rob_flush;
        end
    end

    always_comb begin
        q_ready = '0;
        q_val   = '0;
        for (int k = 0; k < 2; k++) begin
            q_ready[k]               = ready_q[q_id[k*DEPTH_W +: DEPTH_W]];
            q_val[k*XLEN +: XLEN]    = val_q[q_id[k*DEPTH_W +: DEPTH_W]];
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_hit[p] && wb_idx[p] == q_id[k*DEPTH_W +: DEPTH_W]) begin
                    q_ready[k] = 1'b1;
                    // JALR keeps its link value; the writeback only carries the target.
                    if (kind_q[wb_idx[p]] != KIND_JALR) begin
                        q_val[k*XLEN +: XLEN] = wb_val_a[p];
                    end
                end
            end
        end
    end

    assign head1 = head_q + 1'b1;
    assign kind0 = kind_q[head_q];

    always_comb begin
        fire0 = (count_q != '0) && ready_q[head_q] && !rob_flush
                && !(kind0 == KIND_STORE && mem_busy);
        fire1 = fire0 && (kind0 == KIND_REG) && (kind_q[head1] == KIND_REG)
                && (count_q >= COUNT_TWO) && ready_q[head1];
        n_commit    = {1'b0, fire0} + {1'b0, fire1};
        mispredict  = (val_q[head_q][0] != pred_q[head_q]);
        branch_fall = pc_q[head_q] + (c_q[head_q] ? XLEN'(2) : XLEN'(4));
        count_d     = count_q + (DEPTH_W+1)'(alloc_acc) - (DEPTH_W+1)'(n_commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            ready_q        <= '0;
            commit_valid   <= '0;
            commit_rd      <= '0;
            commit_val     <= '0;
            mem_en         <= 1'b0;
            mem_op         <= '0;
            mem_addr       <= '0;
            mem_val        <= '0;
            bp_en          <= 1'b0;
            bp_pc          <= '0;
            bp_taken       <= 1'b0;
            bp_correct     <= 1'b0;
            rob_flush      <= 1'b0;
            rob_correct_pc <= '0;
        end else if (rdy) begin
            if (rob_flush) begin
                // Everything younger than the redirecting instruction is discarded.
                tail_q       <= head_q;
                count_q      <= '0;
                commit_valid <= '0;
                mem_en       <= 1'b0;
                bp_en        <= 1'b0;
                rob_flush    <= 1'b0;
            end else begin
                head_q  <= head_q + DEPTH_W'(n_commit);
                count_q <= count_d;
                if (alloc_acc) begin
                    tail_q          <= tail_q + 1'b1;
                    ready_q[tail_q] <= alloc_ready;
                end
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_hit[p]) ready_q[wb_idx[p]] <= 1'b1;
                end

                commit_valid <= {fire1, fire0 && (kind0 == KIND_REG || kind0 == KIND_JALR)};
                if (fire0 && (kind0 == KIND_REG || kind0 == KIND_JALR)) begin
                    commit_rd[REG_W-1:0] <= rd_q[head_q];
                    commit_val[XLEN-1:0] <= val_q[head_q];
                end
                if (fire1) begin
                    commit_rd[2*REG_W-1:REG_W] <= rd_q[head1];
                    commit_val[2*XLEN-1:XLEN]  <= val_q[head1];
                end

                mem_en <= fire0 && (kind0 == KIND_STORE);
                if (fire0 && kind0 == KIND_STORE) begin
                    mem_op   <= op_q[head_q];
                    mem_addr <= addr_q[head_q];
                    mem_val  <= val_q[head_q];
                end

                bp_en <= fire0 && (kind0 == KIND_BRANCH);
                if (fire0 && kind0 == KIND_BRANCH) begin
                    bp_pc      <= pc_q[head_q];
                    bp_taken   <= val_q[head_q][0];
                    bp_correct <= !mispredict;
                end

                rob_flush <= fire0 && (kind0 == KIND_JALR || (kind0 == KIND_BRANCH && mispredict));
                if (fire0 && kind0 == KIND_JALR) begin
                    rob_correct_pc <= addr_q[head_q];
                end else if (fire0 && kind0 == KIND_BRANCH && mispredict) begin
                    rob_correct_pc <= val_q[head_q][0] ? addr_q[head_q] : branch_fall;
                end
            end
        end
    end

    // Entry payload needs no reset: ready_q and count_q gate every use.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (alloc_acc) begin
                kind_q[tail_q] <= alloc_kind;
                op_q[tail_q]   <= alloc_op;
                rd_q[tail_q]   <= alloc_rd;
                val_q[tail_q]  <= (alloc_kind == KIND_BRANCH) ? '0 : alloc_val;
                addr_q[tail_q] <= alloc_addr;
                pc_q[tail_q]   <= alloc_pc;
                pred_q[tail_q] <= alloc_pred;
                c_q[tail_q]    <= alloc_c;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_hit[p]) begin
                    case (kind_q[wb_idx[p]])
                        KIND_JALR: addr_q[wb_idx[p]] <= wb_addr_a[p];
                        KIND_STORE: begin
                            addr_q[wb_idx[p]] <= wb_addr_a[p];
                            val_q[wb_idx[p]]  <= wb_val_a[p];
                        end
                        default: val_q[wb_idx[p]] <= wb_val_a[p];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc: a fill table plus hand sequences for
// dual commit, branch/JALR redirect, store back-pressure, bypass and wrap.
module tb_reorder_buffer_mc;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        alloc_valid;
    logic [1:0]  alloc_kind;
    logic [5:0]  alloc_op;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [31:0] alloc_val, alloc_addr, alloc_pc;
    logic        alloc_pred, alloc_c;
    logic [3:0]  alloc_id;
    logic        rob_full;
    logic [4:0]  rob_count;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_id;
    logic [63:0] wb_val, wb_addr;
    logic [7:0]  q_id;
    logic [1:0]  q_ready;
    logic [63:0] q_val;
    logic        mem_busy;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd;
    logic [63:0] commit_val;
    logic        mem_en;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr, mem_val;
    logic        bp_en, bp_taken, bp_correct, rob_flush;
    logic [31:0] bp_pc, rob_correct_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       a_valid;
        logic       a_rdy;
        logic [3:0] exp_id;
        logic [4:0] exp_count;
        logic       exp_full;
    } fill_vec_t;

    fill_vec_t  fill_tab [18];
    logic [31:0] got_q [$];
    logic [3:0]  wrap_ids [4];

    reorder_buffer_mc dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_op(alloc_op),
        .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_val(alloc_val),
        .alloc_addr(alloc_addr), .alloc_pred(alloc_pred), .alloc_pc(alloc_pc),
        .alloc_c(alloc_c), .alloc_id(alloc_id), .rob_full(rob_full), .rob_count(rob_count),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .wb_addr(wb_addr),
        .q_id(q_id), .q_ready(q_ready), .q_val(q_val), .mem_busy(mem_busy),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
        .mem_en(mem_en), .mem_op(mem_op), .mem_addr(mem_addr), .mem_val(mem_val),
        .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_correct(bp_correct),
        .rob_flush(rob_flush), .rob_correct_pc(rob_correct_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_alloc(input logic [1:0] kind, input logic [4:0] rd, input logic rdyv,
                             input logic [31:0] val, input logic [31:0] addr,
                             input logic pred, input logic [31:0] pc);
        alloc_valid = 1'b1;
        alloc_kind  = kind;
        alloc_rd    = rd;
        alloc_ready = rdyv;
        alloc_val   = val;
        alloc_addr  = addr;
        alloc_pred  = pred;
        alloc_pc    = pc;
    endtask

    task automatic set_wb(input int p, input logic [3:0] id, input logic [31:0] val,
                          input logic [31:0] addr);
        wb_valid[p]         = 1'b1;
        wb_id[p*4 +: 4]     = id;
        wb_val[p*32 +: 32]  = val;
        wb_addr[p*32 +: 32] = addr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " count"}, rob_count, 0);
        check({tag, " full"}, rob_full, 0);
        check({tag, " alloc_id"}, alloc_id, 0);
        check({tag, " commit_valid"}, commit_valid, 0);
        check({tag, " commit_rd"}, commit_rd, 0);
        check({tag, " commit_val"}, commit_val, 0);
        check({tag, " mem_en"}, mem_en, 0);
        check({tag, " mem_op"}, mem_op, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_val"}, mem_val, 0);
        check({tag, " bp_en"}, bp_en, 0);
        check({tag, " bp_pc"}, bp_pc, 0);
        check({tag, " bp_taken"}, bp_taken, 0);
        check({tag, " bp_correct"}, bp_correct, 0);
        check({tag, " rob_flush"}, rob_flush, 0);
        check({tag, " correct_pc"}, rob_correct_pc, 0);
    endtask

    task automatic capture();
        if (commit_valid[0]) got_q.push_back(commit_val[31:0]);
        if (commit_valid[1]) got_q.push_back(commit_val[63:32]);
    endtask

    initial begin
        // Fill table: row 5 stalls with rdy low, row 17 is the dropped 17th alloc.
        for (int i = 0; i < 18; i++) begin
            if (i < 5) fill_tab[i] = '{1'b1, 1'b1, 4'(i), 5'(i + 1), 1'b0};
            else if (i == 5) fill_tab[i] = '{1'b1, 1'b0, 4'd5, 5'd5, 1'b0};
            else if (i < 17) fill_tab[i] = '{1'b1, 1'b1, 4'(i - 1), 5'(i), (i == 16)};
            else fill_tab[i] = '{1'b1, 1'b1, 4'd0, 5'd16, 1'b1};
        end
        wrap_ids = '{4'd14, 4'd15, 4'd0, 4'd1};

        rst = 1'b0; rdy = 1'b1; alloc_valid = 1'b0; alloc_kind = '0; alloc_op = '0;
        alloc_rd = '0; alloc_ready = 1'b0; alloc_val = '0; alloc_addr = '0;
        alloc_pred = 1'b0; alloc_pc = '0; alloc_c = 1'b0; wb_valid = '0; wb_id = '0;
        wb_val = '0; wb_addr = '0; q_id = '0; mem_busy = 1'b0;

        do_reset();
        check_all_zero("reset");

        // Fill to full and attempt one more.
        for (int i = 0; i < 18; i++) begin
            set_alloc(2'd0, 5'd1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            alloc_valid = fill_tab[i].a_valid;
            rdy = fill_tab[i].a_rdy;
            check($sformatf("fill[%0d] id", i), alloc_id, fill_tab[i].exp_id);
            step();
            check($sformatf("fill[%0d] count", i), rob_count, fill_tab[i].exp_count);
            check($sformatf("fill[%0d] full", i), rob_full, fill_tab[i].exp_full);
        end
        alloc_valid = 1'b0; rdy = 1'b1;
        check("fill tail after drop", alloc_id, 0);

        // Dual commit.
        do_reset();
        set_alloc(2'd0, 5'd5, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); step();
        set_alloc(2'd0, 5'd6, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); step();
        alloc_valid = 1'b0;
        set_wb(1, 4'd1, 32'h22, 32'h0); step();
        wb_valid = '0;
        set_wb(0, 4'd0, 32'h11, 32'h0); step();
        wb_valid = '0;
        check("dual pre commit_valid", commit_valid, 2'b00);
        step();
        check("dual commit_valid", commit_valid, 2'b11);
        check("dual commit_rd", commit_rd, {5'd6, 5'd5});
        check("dual commit_val", commit_val, {32'h22, 32'h11});
        check("dual count", rob_count, 0);
        step();
        check("dual commit_valid drop", commit_valid, 2'b00);

        // Mispredicted branch, then alloc during the flush cycle.
        do_reset();
        set_alloc(2'd2, 5'd0, 1'b0, 32'h0, 32'h140, 1'b0, 32'h100); step();
        alloc_valid = 1'b0;
        set_wb(0, 4'd0, 32'h1, 32'h0); step();
        wb_valid = '0;
        step();
        check("br bp_en", bp_en, 1);
        check("br bp_pc", bp_pc, 32'h100);
        check("br bp_taken", bp_taken, 1);
        check("br bp_correct", bp_correct, 0);
        check("br rob_flush", rob_flush, 1);
        check("br correct_pc", rob_correct_pc, 32'h140);
        set_alloc(2'd0, 5'd3, 1'b1, 32'h7, 32'h0, 1'b0, 32'h0); step();
        alloc_valid = 1'b0;
        check("br flush drop", rob_flush, 0);
        check("br bp_en drop", bp_en, 0);
        check("br count after flush", rob_count, 0);
        check("br tail after flush", alloc_id, 1);

        // Correctly predicted not-taken branch: no redirect.
        do_reset();
        set_alloc(2'd2, 5'd0, 1'b0, 32'h0, 32'h180, 1'b0, 32'h200); step();
        alloc_valid = 1'b0;
        set_wb(0, 4'd0, 32'h0, 32'h0); step();
        wb_valid = '0;
        step();
        check("brok bp_en", bp_en, 1);
        check("brok bp_correct", bp_correct, 1);
        check("brok rob_flush", rob_flush, 0);

        // JALR: link write plus redirect to the written-back target.
        do_reset();
        set_alloc(2'd3, 5'd1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h100); step();
        alloc_valid = 1'b0;
        set_wb(0, 4'd0, 32'hDEAD, 32'h200); step();
        wb_valid = '0;
        step();
        check("jalr commit_valid", commit_valid, 2'b01);
        check("jalr commit_rd", commit_rd[4:0], 1);
        check("jalr commit_val", commit_val[31:0], 32'h104);
        check("jalr rob_flush", rob_flush, 1);
        check("jalr correct_pc", rob_correct_pc, 32'h200);
        step();
        check("jalr flush one cycle", rob_flush, 0);

        // Store blocked by mem_busy.
        do_reset();
        set_alloc(2'd1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        alloc_op = 6'h23;
        step();
        alloc_valid = 1'b0;
        mem_busy = 1'b1;
        set_wb(0, 4'd0, 32'h41, 32'h30000); step();
        wb_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("st busy[%0d] mem_en", i), mem_en, 0);
            check($sformatf("st busy[%0d] count", i), rob_count, 1);
        end
        mem_busy = 1'b0;
        step();
        check("st mem_en", mem_en, 1);
        check("st mem_op", mem_op, 6'h23);
        check("st mem_addr", mem_addr, 32'h30000);
        check("st mem_val", mem_val, 32'h41);
        check("st commit_valid", commit_valid, 0);
        check("st count", rob_count, 0);
        step();
        check("st mem_en single", mem_en, 0);

        // Same-cycle bypass and same-id port priority.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(2'd0, 5'(i + 1), 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); step();
        end
        alloc_valid = 1'b0;
        q_id = {4'd0, 4'd3};
        #1;
        check("byp idle q_ready", q_ready, 2'b00);
        set_wb(0, 4'd3, 32'hDEAD, 32'h0);
        #1;
        check("byp q_ready0", q_ready[0], 1);
        check("byp q_val0", q_val[31:0], 32'hDEAD);
        check("byp q_ready1", q_ready[1], 0);
        step();
        set_wb(0, 4'd3, 32'h1, 32'h0);
        set_wb(1, 4'd3, 32'h2, 32'h0);
        #1;
        check("byp prio bypass", q_val[31:0], 32'h2);
        step();
        wb_valid = '0;
        #1;
        check("byp prio ready", q_ready[0], 1);
        check("byp prio entry", q_val[31:0], 32'h2);

        // Wrap: push head to 14, then four ready entries across the boundary.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_alloc(2'd0, 5'd9, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0); step();
        end
        alloc_valid = 1'b0;
        begin
            int guard = 0;
            while (rob_count != 0 && guard < 40) begin
                step();
                guard++;
            end
            check("wrap drain done", rob_count, 0);
        end
        check("wrap head 14", alloc_id, 14);
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            set_alloc(2'd0, 5'(i + 1), 1'b1, 32'hA0 + 32'(i), 32'h0, 1'b0, 32'h0);
            check($sformatf("wrap id[%0d]", i), alloc_id, wrap_ids[i]);
            step();
            capture();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            capture();
        end
        check("wrap commit count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("wrap commit[%0d]", i), got_q[i], 32'hA0 + 32'(i));
        end

        // Reset in the middle of a commit stream.
        set_alloc(2'd0, 5'd7, 1'b1, 32'h55, 32'h0, 1'b0, 32'h0);
        step();
        step();
        check("mid commit_valid", commit_valid[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        alloc_valid = 1'b0;
        check_all_zero("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
